// File: rtl/niu_sii_inbound_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | niu_sii_inbound_capture: NIU->SII inbound request capture, parity check,   |
// | OQ/BQ header FIFOs, payload steering to data buffer and credit return.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module niu_sii_inbound_capture #(
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic           iol2clk,
    input  logic           rst_l,
    input  logic           niu_sii_hdr_vld,
    input  logic           niu_sii_reqbypass,
    input  logic           niu_sii_datareq,
    input  logic           niu_sii_datareq16,
    input  logic [127:0]   niu_sii_data,
    input  logic [7:0]     niu_sii_parity,
    input  logic [15:0]    niu_sii_be,
    output logic           sii_niu_oqdq,
    output logic           sii_niu_bqdq,
    output logic           oq_vld,
    output logic [127:0]   oq_hdr,
    output logic           oq_wr,
    output logic           oq_len16,
    output logic           oq_perr,
    input  logic           oq_deq,
    output logic           bq_vld,
    output logic [127:0]   bq_hdr,
    output logic           bq_wr,
    output logic           bq_len16,
    output logic           bq_perr,
    input  logic           bq_deq,
    output logic           dbuf_wr_en,
    output logic [PW+2:0]  dbuf_wr_addr,
    output logic [127:0]   dbuf_wr_data,
    output logic [15:0]    dbuf_wr_be,
    output logic           err_proto,
    output logic           err_parity
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    localparam logic [PW:0] c_full_cnt = (PW+1)'(DEPTH);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_beat;
    logic           r_qsel;
    logic           r_len16;
    logic           r_perr_acc;
    logic [127:0]   r_hdr;

    logic [PW-1:0]  r_wr_ptr [2];
    logic [PW-1:0]  r_rd_ptr [2];
    logic [PW:0]    r_cnt    [2];
    logic [127:0]   r_mem_hdr   [2][DEPTH];
    logic [DEPTH-1:0] r_mem_wr    [2];
    logic [DEPTH-1:0] r_mem_len16 [2];
    logic [DEPTH-1:0] r_mem_perr  [2];
    logic [1:0]     r_dq;

    logic           r_err_proto;
    logic           r_err_parity;
    logic           r_dbuf_wr_en;
    logic [PW+2:0]  r_dbuf_wr_addr;
    logic [127:0]   r_dbuf_wr_data;
    logic [15:0]    r_dbuf_wr_be;

    logic [7:0]     w_lane_fail;
    logic           w_perr;
    logic           w_chk;
    logic           w_full_in;
    logic           w_last_beat;
    logic [1:0]     w_vld;
    logic [1:0]     w_pop;
    logic [1:0]     w_push_hit;
    logic           w_push;
    logic           w_push_q;
    logic [127:0]   w_push_hdr;
    logic           w_push_wr;
    logic           w_push_len16;
    logic           w_push_perr;
    logic           w_accept_wr;
    logic           w_proto;
    logic           w_beat_en;

    always_comb begin
        w_lane_fail = '0;
        for (int i = 0; i < 8; i++) begin
            w_lane_fail[i] = niu_sii_parity[i] ^ (^niu_sii_data[16*i +: 16]);
        end
    end

    assign w_perr      = |w_lane_fail;
    assign w_chk       = niu_sii_hdr_vld | (r_state == S_PAYLOAD);
    // Headers are only taken in IDLE, so no reservation is outstanding when
    // fullness is evaluated; the committed count alone decides.
    assign w_full_in   = (r_cnt[niu_sii_reqbypass] == c_full_cnt);
    assign w_last_beat = r_len16 ? (r_beat == 2'd0) : (r_beat == 2'd3);

    assign w_vld[0]   = (r_cnt[0] != '0);
    assign w_vld[1]   = (r_cnt[1] != '0);
    assign w_pop      = {bq_deq & w_vld[1], oq_deq & w_vld[0]};
    assign w_push_hit = {w_push & w_push_q, w_push & ~w_push_q};

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_push_q     = r_qsel;
        w_push_hdr   = r_hdr;
        w_push_wr    = 1'b1;
        w_push_len16 = r_len16;
        w_push_perr  = r_perr_acc | w_perr;
        w_accept_wr  = 1'b0;
        w_proto      = 1'b0;
        w_beat_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (niu_sii_hdr_vld) begin
                    if (w_full_in || (!niu_sii_datareq && niu_sii_datareq16)) begin
                        w_proto = 1'b1;
                    end else if (!niu_sii_datareq) begin
                        w_push       = 1'b1;
                        w_push_q     = niu_sii_reqbypass;
                        w_push_hdr   = niu_sii_data;
                        w_push_wr    = 1'b0;
                        w_push_len16 = 1'b0;
                        w_push_perr  = w_perr;
                    end else begin
                        w_accept_wr = 1'b1;
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                // Every cycle here is a beat; a stray header is flagged and its
                // data is still taken as payload.
                w_beat_en = 1'b1;
                w_proto   = niu_sii_hdr_vld;
                if (w_last_beat) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state        <= S_IDLE;
            r_beat         <= 2'd0;
            r_qsel         <= 1'b0;
            r_len16        <= 1'b0;
            r_perr_acc     <= 1'b0;
            r_hdr          <= '0;
            r_err_proto    <= 1'b0;
            r_err_parity   <= 1'b0;
            r_dbuf_wr_en   <= 1'b0;
            r_dbuf_wr_addr <= '0;
            r_dbuf_wr_data <= '0;
            r_dbuf_wr_be   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_err_proto  <= w_proto;
            r_err_parity <= w_chk & w_perr;
            r_dbuf_wr_en <= w_beat_en;
            if (w_accept_wr) begin
                r_qsel     <= niu_sii_reqbypass;
                r_hdr      <= niu_sii_data;
                r_len16    <= niu_sii_datareq16;
                r_perr_acc <= w_perr;
                r_beat     <= 2'd0;
            end else if (w_beat_en) begin
                r_beat     <= r_beat + 2'd1;
                r_perr_acc <= r_perr_acc | w_perr;
            end
            if (w_beat_en) begin
                r_dbuf_wr_addr <= {r_qsel, r_wr_ptr[r_qsel], r_beat};
                r_dbuf_wr_data <= niu_sii_data;
                r_dbuf_wr_be   <= niu_sii_be;
            end
        end
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int q = 0; q < 2; q++) begin
                r_wr_ptr[q] <= '0;
                r_rd_ptr[q] <= '0;
                r_cnt[q]    <= '0;
            end
            r_dq <= 2'b00;
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (w_push_hit[q]) r_wr_ptr[q] <= r_wr_ptr[q] + PW'(1);
                if (w_pop[q])      r_rd_ptr[q] <= r_rd_ptr[q] + PW'(1);
                r_cnt[q] <= r_cnt[q] + {{PW{1'b0}}, w_push_hit[q]} - {{PW{1'b0}}, w_pop[q]};
            end
            r_dq <= w_pop;
        end
    end

    always_ff @(posedge iol2clk) begin
        if (w_push) begin
            r_mem_hdr[w_push_q][r_wr_ptr[w_push_q]]   <= w_push_hdr;
            r_mem_wr[w_push_q][r_wr_ptr[w_push_q]]    <= w_push_wr;
            r_mem_len16[w_push_q][r_wr_ptr[w_push_q]] <= w_push_len16;
            r_mem_perr[w_push_q][r_wr_ptr[w_push_q]]  <= w_push_perr;
        end
    end

    // Head fields are gated so nothing stale leaks out of an empty FIFO.
    assign oq_vld   = w_vld[0];
    assign oq_hdr   = w_vld[0] ? r_mem_hdr[0][r_rd_ptr[0]] : '0;
    assign oq_wr    = w_vld[0] & r_mem_wr[0][r_rd_ptr[0]];
    assign oq_len16 = w_vld[0] & r_mem_len16[0][r_rd_ptr[0]];
    assign oq_perr  = w_vld[0] & r_mem_perr[0][r_rd_ptr[0]];
    assign bq_vld   = w_vld[1];
    assign bq_hdr   = w_vld[1] ? r_mem_hdr[1][r_rd_ptr[1]] : '0;
    assign bq_wr    = w_vld[1] & r_mem_wr[1][r_rd_ptr[1]];
    assign bq_len16 = w_vld[1] & r_mem_len16[1][r_rd_ptr[1]];
    assign bq_perr  = w_vld[1] & r_mem_perr[1][r_rd_ptr[1]];

    assign sii_niu_oqdq = r_dq[0];
    assign sii_niu_bqdq = r_dq[1];
    assign dbuf_wr_en   = r_dbuf_wr_en;
    assign dbuf_wr_addr = r_dbuf_wr_addr;
    assign dbuf_wr_data = r_dbuf_wr_data;
    assign dbuf_wr_be   = r_dbuf_wr_be;
    assign err_proto    = r_err_proto;
    assign err_parity   = r_err_parity;

endmodule
`default_nettype wire

// File: tb/tb_niu_sii_inbound_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_niu_sii_inbound_capture: directed + random bench with transaction model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_niu_sii_inbound_capture;

    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic          iol2clk = 1'b0;
    logic          rst_l;
    logic          niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16;
    logic [127:0]  niu_sii_data;
    logic [7:0]    niu_sii_parity;
    logic [15:0]   niu_sii_be;
    logic          sii_niu_oqdq, sii_niu_bqdq;
    logic          oq_vld, oq_wr, oq_len16, oq_perr, oq_deq;
    logic          bq_vld, bq_wr, bq_len16, bq_perr, bq_deq;
    logic [127:0]  oq_hdr, bq_hdr;
    logic          dbuf_wr_en;
    logic [PW+2:0] dbuf_wr_addr;
    logic [127:0]  dbuf_wr_data;
    logic [15:0]   dbuf_wr_be;
    logic          err_proto, err_parity;

    always #5 iol2clk = ~iol2clk;

    niu_sii_inbound_capture #(.DEPTH(DEPTH), .PW(PW)) u_dut (
        .iol2clk(iol2clk), .rst_l(rst_l),
        .niu_sii_hdr_vld(niu_sii_hdr_vld), .niu_sii_reqbypass(niu_sii_reqbypass),
        .niu_sii_datareq(niu_sii_datareq), .niu_sii_datareq16(niu_sii_datareq16),
        .niu_sii_data(niu_sii_data), .niu_sii_parity(niu_sii_parity), .niu_sii_be(niu_sii_be),
        .sii_niu_oqdq(sii_niu_oqdq), .sii_niu_bqdq(sii_niu_bqdq),
        .oq_vld(oq_vld), .oq_hdr(oq_hdr), .oq_wr(oq_wr), .oq_len16(oq_len16),
        .oq_perr(oq_perr), .oq_deq(oq_deq),
        .bq_vld(bq_vld), .bq_hdr(bq_hdr), .bq_wr(bq_wr), .bq_len16(bq_len16),
        .bq_perr(bq_perr), .bq_deq(bq_deq),
        .dbuf_wr_en(dbuf_wr_en), .dbuf_wr_addr(dbuf_wr_addr),
        .dbuf_wr_data(dbuf_wr_data), .dbuf_wr_be(dbuf_wr_be),
        .err_proto(err_proto), .err_parity(err_parity)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: each FIFO is a plain queue of requests; one write may
    // be in flight, holding the slot number it will occupy.
    typedef struct packed {
        logic [127:0] hdr;
        logic         wr;
        logic         len16;
        logic         perr;
    } ent_t;

    ent_t         m_oq[$];
    ent_t         m_bq[$];
    bit           m_act;
    bit           m_q;
    logic [127:0] m_hdr;
    bit           m_len16, m_perr;
    int           m_beat, m_slot;
    int           m_pushes [2];
    bit           e_dq [2];
    bit           e_wen, e_proto, e_par;
    int           e_addr;
    logic [127:0] e_wdata;
    logic [15:0]  e_wbe;

    function automatic logic [7:0] good_par(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = (($countones(d[16*i +: 16]) % 2) == 1);
        return p;
    endfunction

    function automatic bit lanes_bad(input logic [127:0] d, input logic [7:0] p);
        return p != good_par(d);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_oq.delete();
        m_bq.delete();
        m_act = 0; m_q = 0; m_beat = 0; m_slot = 0;
        m_pushes = '{0, 0};
        e_dq = '{0, 0};
        e_wen = 0; e_proto = 0; e_par = 0; e_addr = 0;
        e_wdata = '0; e_wbe = '0;
    endtask

    task automatic model_push(input bit q, input logic [127:0] h, input bit wr,
                              input bit l16, input bit pe);
        ent_t e;
        e.hdr = h; e.wr = wr; e.len16 = l16; e.perr = pe;
        if (q) m_bq.push_back(e); else m_oq.push_back(e);
        m_pushes[q]++;
    endtask

    task automatic model_step();
        bit fail, full;
        if (!rst_l) begin
            model_reset();
            return;
        end
        fail  = lanes_bad(niu_sii_data, niu_sii_parity);
        full  = (niu_sii_reqbypass ? m_bq.size() : m_oq.size()) >= DEPTH;
        e_par = (niu_sii_hdr_vld || m_act) && fail;
        e_dq[0] = oq_deq && (m_oq.size() > 0);
        e_dq[1] = bq_deq && (m_bq.size() > 0);
        e_wen   = m_act;
        e_addr  = int'(m_q) * 32 + m_slot * 4 + m_beat;
        e_wdata = niu_sii_data;
        e_wbe   = niu_sii_be;
        if (m_act) e_proto = niu_sii_hdr_vld;
        else       e_proto = niu_sii_hdr_vld && (full || (!niu_sii_datareq && niu_sii_datareq16));
        if (e_dq[0]) void'(m_oq.pop_front());
        if (e_dq[1]) void'(m_bq.pop_front());
        if (m_act) begin
            m_perr = m_perr | fail;
            m_beat++;
            if (m_beat == (m_len16 ? 1 : 4)) begin
                model_push(m_q, m_hdr, 1'b1, m_len16, m_perr);
                m_act = 0;
            end
        end else if (niu_sii_hdr_vld && !e_proto) begin
            if (!niu_sii_datareq) begin
                model_push(niu_sii_reqbypass, niu_sii_data, 1'b0, 1'b0, fail);
            end else begin
                m_act = 1; m_q = niu_sii_reqbypass; m_hdr = niu_sii_data;
                m_len16 = niu_sii_datareq16; m_perr = fail; m_beat = 0;
                m_slot = m_pushes[m_q] % DEPTH;
            end
        end
    endtask

    task automatic compare_all();
        if (m_oq.size() > 0) begin
            check("oq_vld", oq_vld, 1'b1);
            check("oq_hdr", oq_hdr, m_oq[0].hdr);
            check("oq_wr", oq_wr, m_oq[0].wr);
            check("oq_len16", oq_len16, m_oq[0].len16);
            check("oq_perr", oq_perr, m_oq[0].perr);
        end else begin
            check("oq_vld", oq_vld, 1'b0);
        end
        if (m_bq.size() > 0) begin
            check("bq_vld", bq_vld, 1'b1);
            check("bq_hdr", bq_hdr, m_bq[0].hdr);
            check("bq_wr", bq_wr, m_bq[0].wr);
            check("bq_len16", bq_len16, m_bq[0].len16);
            check("bq_perr", bq_perr, m_bq[0].perr);
        end else begin
            check("bq_vld", bq_vld, 1'b0);
        end
        check("oqdq", sii_niu_oqdq, e_dq[0]);
        check("bqdq", sii_niu_bqdq, e_dq[1]);
        check("dbuf_wr_en", dbuf_wr_en, e_wen);
        if (e_wen) begin
            check("dbuf_wr_addr", dbuf_wr_addr, e_addr);
            check("dbuf_wr_data", dbuf_wr_data, e_wdata);
            check("dbuf_wr_be", dbuf_wr_be, e_wbe);
        end
        check("err_proto", err_proto, e_proto);
        check("err_parity", err_parity, e_par);
    endtask

    task automatic rst_zero_check();
        check("rst_oq_vld", oq_vld, 0);     check("rst_oq_hdr", oq_hdr, 0);
        check("rst_oq_wr", oq_wr, 0);       check("rst_oq_len16", oq_len16, 0);
        check("rst_oq_perr", oq_perr, 0);   check("rst_bq_vld", bq_vld, 0);
        check("rst_bq_hdr", bq_hdr, 0);     check("rst_bq_wr", bq_wr, 0);
        check("rst_bq_len16", bq_len16, 0); check("rst_bq_perr", bq_perr, 0);
        check("rst_oqdq", sii_niu_oqdq, 0); check("rst_bqdq", sii_niu_bqdq, 0);
        check("rst_wr_en", dbuf_wr_en, 0);  check("rst_wr_addr", dbuf_wr_addr, 0);
        check("rst_wr_data", dbuf_wr_data, 0); check("rst_wr_be", dbuf_wr_be, 0);
        check("rst_err_proto", err_proto, 0);  check("rst_err_parity", err_parity, 0);
    endtask

    task automatic step();
        model_step();
        @(posedge iol2clk);
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        niu_sii_hdr_vld = 0; niu_sii_reqbypass = 0; niu_sii_datareq = 0;
        niu_sii_datareq16 = 0; niu_sii_data = '0; niu_sii_parity = '0;
        niu_sii_be = '0; oq_deq = 0; bq_deq = 0;
    endtask

    task automatic drive_hdr(input logic byp, input logic dreq, input logic d16,
                             input logic [127:0] d);
        set_idle();
        niu_sii_hdr_vld = 1; niu_sii_reqbypass = byp; niu_sii_datareq = dreq;
        niu_sii_datareq16 = d16; niu_sii_data = d; niu_sii_parity = good_par(d);
    endtask

    task automatic drive_beat(input logic [127:0] d, input logic [15:0] be,
                              input logic [7:0] pflip);
        set_idle();
        niu_sii_data = d; niu_sii_be = be; niu_sii_parity = good_par(d) ^ pflip;
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH + 2 && (m_oq.size() > 0 || m_bq.size() > 0); k++) begin
            set_idle(); oq_deq = 1; bq_deq = 1;
            step();
        end
        set_idle();
    endtask

    task automatic random_drive(input bit busy_deq);
        set_idle();
        if (m_act) begin
            niu_sii_data = rnd128(); niu_sii_be = 16'($urandom);
            niu_sii_parity = good_par(niu_sii_data);
            if ($urandom_range(0, 24) == 0) begin
                niu_sii_hdr_vld = 1;
                niu_sii_datareq = 1'($urandom_range(0, 1));
                niu_sii_reqbypass = 1'($urandom_range(0, 1));
            end
        end else if ($urandom_range(0, 3) != 0) begin
            niu_sii_hdr_vld   = 1;
            niu_sii_reqbypass = 1'($urandom_range(0, 1));
            niu_sii_datareq   = 1'($urandom_range(0, 1));
            niu_sii_datareq16 = niu_sii_datareq ? 1'($urandom_range(0, 1))
                                                : ($urandom_range(0, 9) == 0);
            niu_sii_data   = rnd128();
            niu_sii_parity = good_par(niu_sii_data);
        end
        if ($urandom_range(0, 11) == 0)
            niu_sii_parity = niu_sii_parity ^ (8'(1) << $urandom_range(0, 7));
        oq_deq = busy_deq ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
        bq_deq = busy_deq ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        rst_l = 0;
        model_reset();
        repeat (2) @(posedge iol2clk);
        #1;
        rst_zero_check();
        rst_l = 1;

        // Read into OQ, then dequeue and watch the single credit pulse.
        drive_hdr(0, 0, 0, 128'hAB_0000001040);
        step();
        check("tp_rd_hdr", oq_hdr, 128'hAB_0000001040);
        check("tp_rd_wr", oq_wr, 0);
        set_idle(); step(); step();
        oq_deq = 1; step();
        check("tp_oqdq", sii_niu_oqdq, 1);
        set_idle(); step();
        check("tp_oqdq_once", sii_niu_oqdq, 0);

        // 64B write to BQ, slot 0.
        drive_hdr(1, 1, 0, rnd128()); step();
        for (int i = 0; i < 4; i++) begin
            drive_beat(rnd128(), 16'hFFFF, 8'h00); step();
            check("tp_bq_addr", dbuf_wr_addr, 32'h20 + i);
        end
        check("tp_bq_vld", bq_vld, 1);
        check("tp_bq_wr", bq_wr, 1);
        check("tp_bq_len16", bq_len16, 0);

        // 16B write to OQ (slot 1) followed immediately by a read header.
        drive_hdr(0, 1, 1, rnd128()); step();
        drive_beat(rnd128(), 16'h00FF, 8'h00); step();
        check("tp_w16_addr", dbuf_wr_addr, 6'h04);
        drive_hdr(0, 0, 0, rnd128()); step();
        check("tp_b2b_proto", err_proto, 0);
        set_idle(); step();
        check("tp_order_head_wr", oq_wr, 1);
        drain();

        // Fill OQ, then overflow with and without a same-cycle dequeue.
        for (int i = 0; i < DEPTH; i++) begin
            drive_hdr(0, 0, 0, rnd128()); step();
        end
        drive_hdr(0, 0, 0, rnd128()); step();
        check("tp_full_proto", err_proto, 1);
        drive_hdr(0, 0, 0, rnd128()); oq_deq = 1; step();
        check("tp_full_deq_proto", err_proto, 1);
        drain();

        // Parity corruption on beat 2 of a 64B OQ write.
        drive_hdr(0, 1, 0, rnd128()); step();
        for (int i = 0; i < 4; i++) begin
            drive_beat(rnd128(), 16'hFFFF, (i == 2) ? 8'h08 : 8'h00); step();
            check("tp_par_pulse", err_parity, (i == 2));
        end
        check("tp_perr_set", oq_perr, 1);
        drive_hdr(0, 0, 0, rnd128()); step();
        set_idle(); oq_deq = 1; step();
        check("tp_perr_clean", oq_perr, 0);
        drain();

        // Asynchronous reset in the middle of a BQ payload.
        drive_hdr(1, 0, 0, rnd128()); step();
        drive_hdr(1, 1, 0, rnd128()); step();
        drive_beat(rnd128(), 16'hFFFF, 8'h00); step();
        drive_beat(rnd128(), 16'hFFFF, 8'h00);
        #3 rst_l = 0;
        #1 rst_zero_check();
        model_reset();
        @(posedge iol2clk);
        #1;
        set_idle();
        rst_l = 1;
        drive_hdr(0, 0, 0, rnd128()); step();
        check("tp_post_rst_vld", oq_vld, 1);
        drive_hdr(0, 1, 1, rnd128()); step();
        drive_beat(rnd128(), 16'h0F0F, 8'h00); step();
        check("tp_post_rst_addr", dbuf_wr_addr, 6'h04);
        drain();

        for (int n = 0; n < 3000; n++) begin
            random_drive(((n / 200) % 2) == 1);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
